// File: rtl/sine_lut_generator_if.sv
// Phase-in / sample-out bundle between the phase accumulator and the sine generator.
// With AMPLITUDE_SCALE_EN defined the bundle also carries the Q1.15 gain word.
interface sine_lut_generator_if #(
  parameter int PHASE_W = 10,
  parameter int DATA_W  = 16
);
  logic               en;
  logic [PHASE_W-1:0] phase_in;
  logic [DATA_W-1:0]  sample_out;
  logic               sample_valid;
`ifdef AMPLITUDE_SCALE_EN
  logic [15:0]        gain;

  modport master (output en, phase_in, gain, input sample_out, sample_valid);
  modport slave  (input en, phase_in, gain, output sample_out, sample_valid);
`else
  modport master (output en, phase_in, input sample_out, sample_valid);
  modport slave  (input en, phase_in, output sample_out, sample_valid);
`endif
endinterface

// File: rtl/sine_lut_generator.sv
// Phase word to signed sine sample via a quarter-wave ROM with quadrant folding.
// Optional AMPLITUDE_SCALE_EN adds a Q1.15 gain stage (latency 3 -> 4).
module sine_lut_generator #(
  parameter int PHASE_W = 10,
  parameter int DATA_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  sine_lut_generator_if.slave  bus
);

  localparam int ADDR_W = PHASE_W - 2;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam logic signed [127:0] PI_Q48 = 128'sd884279719003555;
  localparam logic signed [127:0] AMP_Q  = (128'sd1 <<< (DATA_W - 1)) - 128'sd1;
  localparam logic signed [127:0] HALF_Q = 128'sd1 <<< 47;

  // Elaboration-time table: round(AMP * sin(pi*(2i+1)/2**PHASE_W)), Taylor series in Q48.
  function automatic logic [DATA_W-1:0] sine_entry(input int idx);
    logic signed [127:0] x;
    logic signed [127:0] x2;
    logic signed [127:0] term;
    logic signed [127:0] sum;
    logic signed [127:0] den;
    logic signed [127:0] scaled;
    x    = (PI_Q48 * 128'(2 * idx + 1)) >>> PHASE_W;
    x2   = (x * x) >>> 48;
    term = x;
    sum  = x;
    for (int k = 1; k <= 12; k++) begin
      den  = 128'(2 * k * (2 * k + 1));
      term = -((term * x2) >>> 48) / den;
      sum  = sum + term;
    end
    scaled = (sum * AMP_Q + HALF_Q) >>> 48;
    return scaled[DATA_W-1:0];
  endfunction

  logic [DATA_W-1:0] rom [DEPTH];

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_rom
      localparam logic [DATA_W-1:0] ENTRY = sine_entry(gi);
      assign rom[gi] = ENTRY;
    end
  endgenerate

  logic               first_flag_q, first_flag_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic               v0_q, v0_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               neg1_q, neg1_d;
  logic               v1_q, v1_d;
  logic [DATA_W-1:0]  rom_q, rom_d;
  logic               neg2_q, neg2_d;
  logic               v2_q, v2_d;
  logic [DATA_W-1:0]  sign_q, sign_d;
  logic               v3_q, v3_d;

  always_comb begin
    first_flag_d = first_flag_q;
    phase_d      = phase_q;
    v0_d         = v0_q;
    addr_d       = addr_q;
    neg1_d       = neg1_q;
    v1_d         = v1_q;
    rom_d        = rom_q;
    neg2_d       = neg2_q;
    v2_d         = v2_q;
    sign_d       = sign_q;
    v3_d         = v3_q;
    if (bus.en) begin
      phase_d      = bus.phase_in;
      v0_d         = first_flag_q | (bus.phase_in != phase_q);
      first_flag_d = 1'b0;
      // Odd quadrants read the table mirrored; the upper half is negated later.
      addr_d = phase_q[PHASE_W-2] ? ~phase_q[ADDR_W-1:0] : phase_q[ADDR_W-1:0];
      neg1_d = phase_q[PHASE_W-1];
      v1_d   = v0_q;
      rom_d  = rom[addr_q];
      neg2_d = neg1_q;
      v2_d   = v1_q;
      v3_d   = v2_q;
      if (v2_q) begin
        sign_d = neg2_q ? -rom_q : rom_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      first_flag_q <= 1'b1;
      phase_q      <= '0;
      v0_q         <= 1'b0;
      addr_q       <= '0;
      neg1_q       <= 1'b0;
      v1_q         <= 1'b0;
      neg2_q       <= 1'b0;
      v2_q         <= 1'b0;
      sign_q       <= '0;
      v3_q         <= 1'b0;
    end else begin
      first_flag_q <= first_flag_d;
      phase_q      <= phase_d;
      v0_q         <= v0_d;
      addr_q       <= addr_d;
      neg1_q       <= neg1_d;
      v1_q         <= v1_d;
      neg2_q       <= neg2_d;
      v2_q         <= v2_d;
      sign_q       <= sign_d;
      v3_q         <= v3_d;
    end
  end

  // ROM output register kept free of reset so it maps onto the block RAM read port.
  always_ff @(posedge clk) begin
    rom_q <= rom_d;
  end

`ifdef AMPLITUDE_SCALE_EN
  localparam logic signed [DATA_W+1:0] SAT_MAX = $signed({3'b000, {(DATA_W-1){1'b1}}});
  localparam logic signed [DATA_W+1:0] SAT_MIN = $signed({3'b111, {(DATA_W-1){1'b0}}});

  logic signed [DATA_W+16:0] prod;
  logic signed [DATA_W+1:0]  shifted;
  logic [DATA_W-1:0]         scaled_q, scaled_d;
  logic                      v4_q, v4_d;

  always_comb begin
    prod     = $signed({{17{sign_q[DATA_W-1]}}, sign_q})
             * $signed({{DATA_W{1'b0}}, 1'b0, bus.gain});
    shifted  = prod[DATA_W+16:15];
    scaled_d = scaled_q;
    v4_d     = v4_q;
    if (bus.en) begin
      v4_d = v3_q;
      if (v3_q) begin
        if (shifted > SAT_MAX) begin
          scaled_d = SAT_MAX[DATA_W-1:0];
        end else if (shifted < SAT_MIN) begin
          scaled_d = SAT_MIN[DATA_W-1:0];
        end else begin
          scaled_d = shifted[DATA_W-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scaled_q <= '0;
      v4_q     <= 1'b0;
    end else begin
      scaled_q <= scaled_d;
      v4_q     <= v4_d;
    end
  end

  assign bus.sample_out   = scaled_q;
  assign bus.sample_valid = v4_q & bus.en;
`else
  assign bus.sample_out   = sign_q;
  assign bus.sample_valid = v3_q & bus.en;
`endif

endmodule

// File: tb/tb_sine_lut_generator.sv
// Scoreboard bench for sine_lut_generator; expected samples come from a $sin reference
// or literal values, tagged with the enabled-cycle index at which the strobe is due.
module tb_sine_lut_generator;
  localparam int PHASE_W = 10;
  localparam int DATA_W  = 16;
`ifdef AMPLITUDE_SCALE_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 3;
`endif

  typedef struct {
    int phase;
    int value;
    int due;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  sine_lut_generator_if #(.PHASE_W(PHASE_W), .DATA_W(DATA_W)) bus ();

  sine_lut_generator #(.PHASE_W(PHASE_W), .DATA_W(DATA_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   en_cyc      = 0;
  bit   m_first     = 1'b1;
  int   m_prev      = 0;
`ifdef AMPLITUDE_SCALE_EN
  int   gain_now    = 32768;
`endif

  task automatic check(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int ref_sample(input int p);
    real x;
    int  v;
`ifdef AMPLITUDE_SCALE_EN
    longint s;
`endif
    x = 32767.0 * $sin(2.0 * 3.14159265358979323846 * (real'(p) + 0.5) / 1024.0);
    v = (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(0.5 - x);
`ifdef AMPLITUDE_SCALE_EN
    s = (longint'(v) * longint'(gain_now)) >>> 15;
    if (s > 32767) s = 32767;
    else if (s < -32768) s = -32768;
    v = int'(s);
`endif
    return v;
  endfunction

  // The drive cycle will be enabled cycle en_cyc+1; its strobe shows LAT+1 enabled cycles later.
  task automatic push(input int p, input int v);
    exp_t e;
    e.phase = p;
    e.value = v;
    e.due   = en_cyc + LAT + 2;
    sb.push_back(e);
  endtask

  task automatic step(input int p, input bit e);
    @(posedge clk);
    #1;
    bus.phase_in = PHASE_W'(p);
    bus.en       = e;
    if (e) begin
      if (m_first || p != m_prev) push(p, ref_sample(p));
      m_first = 1'b0;
      m_prev  = p;
    end
  endtask

  task automatic step_k(input int p, input int v);
    @(posedge clk);
    #1;
    bus.phase_in = PHASE_W'(p);
    bus.en       = 1'b1;
    push(p, v);
    m_first = 1'b0;
    m_prev  = p;
  endtask

  task automatic drain();
    repeat (LAT + 4) step(m_prev, 1'b1);
  endtask

  always @(negedge clk) begin
    bit   exp_v;
    exp_t e;
    if (!rst) begin
      if (bus.en) begin
        en_cyc++;
        exp_v = (sb.size() > 0) && (sb[0].due == en_cyc);
        check("strobe", int'(bus.sample_valid), int'(exp_v));
        if (exp_v) begin
          e = sb.pop_front();
          check("sample", int'($signed(bus.sample_out)), e.value);
          $display("[%0t] phase %0d -> sample %0d (want %0d)", $time, e.phase,
                   int'($signed(bus.sample_out)), e.value);
        end else if (sb.size() > 0 && sb[0].due < en_cyc) begin
          void'(sb.pop_front());
        end
      end else begin
        check("stall_strobe", int'(bus.sample_valid), 0);
      end
    end
  end

  initial begin
    rst          = 1'b1;
    bus.en       = 1'b0;
    bus.phase_in = '0;
`ifdef AMPLITUDE_SCALE_EN
    bus.gain     = 16'h8000;
`endif
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_sample_out", int'($signed(bus.sample_out)), 0);
    check("rst_sample_valid", int'(bus.sample_valid), 0);

    // First phase after reset produces a sample, then silence while it holds.
    step_k(0, 101);
    repeat (8) step(0, 1'b1);

    // Quadrant boundaries back-to-back, then the 1023 -> 0 wrap.
    step(100, 1'b1);
    step_k(0, 101);
    step_k(255, 32767);
    step_k(256, 32767);
    step_k(511, 101);
    step_k(512, -101);
    step_k(767, -32767);
    step_k(768, -32767);
    step_k(1023, -101);
    step_k(0, 101);
    repeat (6) step(0, 1'b1);

    // Long idle accumulator, then single increments.
    step(300, 1'b1);
    repeat (205) step(300, 1'b1);
    for (int j = 1; j <= 4; j++) begin
      step(300 + j, 1'b1);
      step(300 + j, 1'b1);
    end
    for (int j = 0; j < 10; j++) step(700 + j, 1'b1);

    // Stall with the sample at each pipeline depth.
    for (int k = 0; k <= LAT; k++) begin
      step(410 + k, 1'b1);
      repeat (k) step(410 + k, 1'b1);
      repeat (5) step(410 + k, 1'b0);
      repeat (LAT + 3) step(410 + k, 1'b1);
    end

    // Reset with two samples in flight; only the re-armed first phase may strobe.
    step(600, 1'b1);
    step(601, 1'b1);
    @(posedge clk);
    #1;
    rst    = 1'b1;
    bus.en = 1'b0;
    sb.delete();
    m_first = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_sample_out", int'($signed(bus.sample_out)), 0);
    check("midrst_sample_valid", int'(bus.sample_valid), 0);
    repeat (6) step(601, 1'b0);
    repeat (LAT + 4) step(601, 1'b1);

    // Random phases with random stalls.
    for (int n = 0; n < 80; n++) begin
      step(($urandom_range(1, 0) != 0) ? m_prev : int'($urandom_range(1023, 0)),
           $urandom_range(3, 0) != 0);
    end
    drain();

`ifdef AMPLITUDE_SCALE_EN
    bus.gain = 16'h4000;
    gain_now = 16384;
    step_k(255, 16383);
    drain();
    bus.gain = 16'h8000;
    gain_now = 32768;
    step_k(767, -32767);
    drain();
`endif

    check("scoreboard_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
